// File: rtl/xs3_serial_rx_pkg.sv
// xs3_serial_rx_pkg: shared state encoding and Excess-3 code constants
package xs3_serial_rx_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_e;
   localparam logic [3:0] XS3_MIN  = 4'b0011;
   localparam logic [3:0] XS3_MAX  = 4'b1100;
   localparam logic [3:0] XS3_ZERO = 4'b0011;
endpackage

// File: rtl/xs3_legal_chk.sv
// xs3_legal_chk: flags a 4-bit code as a legal Excess-3 digit; built only with XS3_CHECK_EN
`ifdef XS3_CHECK_EN
module xs3_legal_chk
   import xs3_serial_rx_pkg::*;
(
   input  logic [3:0] code,
   output logic       legal
);
   assign legal = (code >= XS3_MIN) && (code <= XS3_MAX);
endmodule
`endif

// File: rtl/xs3_serial_rx.sv
// xs3_serial_rx: serial Excess-3 digit receiver with legality check and valid/ready output; XS3_CHECK_EN enables the check
module xs3_serial_rx
   import xs3_serial_rx_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       bit_in,
   input  logic       out_ready,
   output logic [3:0] digit,
   output logic       out_valid,
   output logic       err,
   output logic       busy,
   output logic [3:0] err_cnt
);
   state_e     state_q, state_d;
   logic [3:0] sh_q, sh_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] digit_q, digit_d;
   logic [3:0] err_cnt_q, err_cnt_d;
   logic       legal;

`ifdef XS3_CHECK_EN
   xs3_legal_chk u_chk (
      .code  (sh_q),
      .legal (legal)
   );
`else
   assign legal = 1'b1;
`endif

   // next-state: collect four bits, judge the code, then hold it until accepted
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      digit_d   = digit_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SHIFT;
            cnt_d   = 2'd0;
         end
         SHIFT: begin
            sh_d    = MSB_FIRST ? {sh_q[2:0], bit_in} : {bit_in, sh_q[3:1]};
            cnt_d   = cnt_q + 2'd1;
            state_d = (cnt_q == 2'd3) ? CHECK : SHIFT;
         end
         CHECK: begin
            state_d = legal ? HOLD : IDLE;
            if (legal) digit_d = sh_q;
            else if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset discards any partial transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sh_q      <= 4'd0;
         cnt_q     <= 2'd0;
         digit_q   <= XS3_ZERO;
         err_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign digit     = digit_q;
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign err       = (state_q == CHECK) && !legal;
   assign err_cnt   = err_cnt_q;
endmodule
